keypad_scanner: RTL and testbench
=================================

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 1250, clocks each column is driven before rows are sampled.
REQ-002 SHALL have parameter DEB_CYCLES, default 250000, clocks a press or release must stay stable to be accepted.
REQ-003 SHALL have one clock; reset is synchronous and active-high. Ports are named clk and reset.
REQ-004 clk  input  1  system clock.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 row  input  4  keypad rows, active-low, externally pulled up, asynchronous to clk.
REQ-007 col  output  4  keypad column drive, active-low one-hot.
REQ-008 num  output  4  digit value 0-9 of the held digit key.
REQ-009 numPressed  output  1  level: debounced digit key held.
REQ-010 opt  output  3  operation code of the held operator key.
REQ-011 optPressed  output  1  level: debounced operator key held.
REQ-012 submit  output  1  level: debounced submit key held.

Function
REQ-013 row SHALL pass through a 2-flop synchronizer before any use; all row references below mean the synchronized value.
REQ-014 Key index SHALL be col_idx*4 + row_idx, where row_idx is the lowest-numbered low row in the driven column.
REQ-015 Index mapping SHALL be: 0-9 → digit 0-9; 10→opt 0; 11→opt 1; 12→opt 2; 13→opt 4; 14→opt 5; 15→submit.
REQ-016 FSM states SHALL be SCAN, PRESS_DEB, HELD and REL_DEB.
REQ-017 SCAN: col SHALL rotate 1110→1101→1011→0111→1110, advancing every SCAN_DIV clocks.
REQ-017a In SCAN, rows SHALL be sampled on the last dwell clock; any low row latches the candidate index and goes to PRESS_DEB with col frozen.
REQ-018 PRESS_DEB: the counter SHALL count while the decoded index equals the candidate.
REQ-018a In PRESS_DEB, any mismatch or all rows high SHALL return to SCAN, resuming at the next column.
REQ-018b In PRESS_DEB, count reaching DEB_CYCLES-1 SHALL enter HELD.
REQ-019 HELD: exactly one of numPressed/optPressed/submit SHALL be 1, chosen by the candidate class.
REQ-019a num and opt SHALL be stable for the whole of HELD, and both SHALL be registered outputs.
REQ-020 HELD: all rows high SHALL enter REL_DEB.
REQ-020a Other keys pressed while in HELD SHALL be ignored.
REQ-021 REL_DEB: the outputs of REQ-019 SHALL stay asserted.
REQ-021a In REL_DEB, DEB_CYCLES consecutive clocks of all rows high SHALL deassert every press output on the same edge and return to SCAN.
REQ-021b In REL_DEB, any low row SHALL return to HELD and clear the counter.
REQ-022 Latency: press outputs SHALL rise at most 4*SCAN_DIV + DEB_CYCLES + 3 clocks after a stable press.
REQ-022a Press outputs SHALL fall exactly DEB_CYCLES + 3 clocks after a stable release, counted from the row pin.
REQ-023 Two keys in the same column: the lower row index SHALL win. Two keys in different columns: the first column scanned SHALL win.
REQ-024 num SHALL be 0 when numPressed=0, and opt SHALL be 0 when optPressed=0.
REQ-025 Counters SHALL saturate and never wrap.

Reset
REQ-026 reset=1 SHALL, on the next clk edge: col=1110, num=0, opt=0, numPressed=0, optPressed=0, submit=0, state SCAN, all counters and synchronizer flops cleared.
REQ-027 reset asserted mid-press SHALL drop all press outputs on that edge.
REQ-027a After reset is released, a still-held key SHALL be re-detected only through a full PRESS_DEB.

Structure
REQ-028 A shared package SHALL hold the state encoding, the key-index constants, the opt codes (0,1,2,4,5) and the index→class/value mapping function.
REQ-029 One sub-module, key_debounce_counter, SHALL implement the saturating stable-count: inputs clear and enable, output done.
REQ-030 The column rotator, synchronizer and FSM SHALL stay in keypad_scanner.

Verification (SCAN_DIV=4, DEB_CYCLES=8)
REQ-031 Hold key index 7 (col 1, row 3) for 100 clocks → numPressed=1 with num=7 within 30 clocks; release → numPressed falls exactly 11 clocks after the row goes high.
REQ-032 Key 14 held → optPressed=1, opt=5, numPressed=0, submit=0; key 15 held → submit=1 only.
REQ-033 Key 3 bounced low/high every 3 clocks for 40 clocks, then stable → no press output during the bounce; a single clean press after it.
REQ-034 Keys 4 and 6 held together → num=4. Then key 9 added while in HELD → num stays 4 until all keys are released.
REQ-035 reset pulsed for 1 clock while key 2 is held → outputs 0 on that edge, col=1110; numPressed re-asserts with num=2 after the full debounce.
REQ-036 Release glitch: rows high for 5 clocks, then low again → press output never falls.

Source files
------------

// File: rtl/keypad_scanner_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : keypad_scanner_pkg
//  Brief    : Shared types, key-index constants, operator codes and the
//             key-index to class/value mapping for the 4x4 keypad scanner.
//  Revision : 1.0  initial release
// ============================================================================
package keypad_scanner_pkg;

  // Scanner FSM state encoding
  typedef enum logic [1:0] {
    SCAN      = 2'd0,
    PRESS_DEB = 2'd1,
    HELD      = 2'd2,
    REL_DEB   = 2'd3
  } state_t;

  // Which press output a key drives
  typedef enum logic [1:0] {
    CLS_NUM    = 2'd0,
    CLS_OPT    = 2'd1,
    CLS_SUBMIT = 2'd2
  } key_class_t;

  typedef struct packed {
    key_class_t cls;
    logic [3:0] value;
  } key_info_t;

  // Key indices of the non-digit keys (index = col*4 + row)
  localparam logic [3:0] KEY_OPT0   = 4'd10;
  localparam logic [3:0] KEY_OPT1   = 4'd11;
  localparam logic [3:0] KEY_OPT2   = 4'd12;
  localparam logic [3:0] KEY_OPT4   = 4'd13;
  localparam logic [3:0] KEY_OPT5   = 4'd14;
  localparam logic [3:0] KEY_SUBMIT = 4'd15;

  // Operation codes reported on opt
  localparam logic [2:0] OPT_CODE_0 = 3'd0;
  localparam logic [2:0] OPT_CODE_1 = 3'd1;
  localparam logic [2:0] OPT_CODE_2 = 3'd2;
  localparam logic [2:0] OPT_CODE_4 = 3'd4;
  localparam logic [2:0] OPT_CODE_5 = 3'd5;

  // Map a key index to its output class and digit/operation value
  function automatic key_info_t decode_key(input logic [3:0] idx);
    key_info_t info;
    info.cls   = CLS_NUM;
    info.value = idx;
    case (idx)
      KEY_OPT0:   begin info.cls = CLS_OPT;    info.value = {1'b0, OPT_CODE_0}; end
      KEY_OPT1:   begin info.cls = CLS_OPT;    info.value = {1'b0, OPT_CODE_1}; end
      KEY_OPT2:   begin info.cls = CLS_OPT;    info.value = {1'b0, OPT_CODE_2}; end
      KEY_OPT4:   begin info.cls = CLS_OPT;    info.value = {1'b0, OPT_CODE_4}; end
      KEY_OPT5:   begin info.cls = CLS_OPT;    info.value = {1'b0, OPT_CODE_5}; end
      KEY_SUBMIT: begin info.cls = CLS_SUBMIT; info.value = 4'd0;               end
      default:    ;
    endcase
    return info;
  endfunction

  // Lowest-numbered active-low row; only meaningful when some row is low
  function automatic logic [1:0] first_low_row(input logic [3:0] rows);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!rows[i]) r = 2'(i);
    end
    return r;
  endfunction

endpackage : keypad_scanner_pkg
`default_nettype wire

// File: rtl/keypad_scanner_debounce_counter.sv
`default_nettype none
// ============================================================================
//  Module   : key_debounce_counter
//  Brief    : Saturating stable-time counter. done is high once enable has
//             been seen DEB_CYCLES-1 times since the last clear.
//  Revision : 1.0  initial release
// ============================================================================
module key_debounce_counter #(
  parameter int DEB_CYCLES = 250000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic done
);

  localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic [CNT_W-1:0] count;

  // Count enabled clocks, holding at the terminal value instead of wrapping
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && (count != CNT_LAST)) begin
      count <= count + 1'b1;
    end
  end

  assign done = (count == CNT_LAST);

endmodule : key_debounce_counter
`default_nettype wire

// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : keypad_scanner
//  Brief    : 4x4 matrix keypad scanner with press/release debounce. Drives
//             one active-low column at a time, decodes the first low row and
//             reports a held digit, operator or submit key as levels.
//  Revision : 1.0  initial release
// ============================================================================
module keypad_scanner
  import keypad_scanner_pkg::*;
#(
  parameter int SCAN_DIV   = 1250,
  parameter int DEB_CYCLES = 250000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] num,
  output logic       numPressed,
  output logic [2:0] opt,
  output logic       optPressed,
  output logic       submit
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  logic [3:0]       row_meta;
  logic [3:0]       row_sync;
  state_t           state;
  state_t           state_next;
  logic [1:0]       col_idx;
  logic [1:0]       col_idx_next;
  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_next;
  logic [3:0]       cand;
  logic [3:0]       cand_next;
  logic [3:0]       num_next;
  logic [2:0]       opt_next;
  logic             num_pressed_next;
  logic             opt_pressed_next;
  logic             submit_next;
  logic             deb_clear;
  logic             deb_enable;
  logic             deb_done;
  logic             any_low;
  logic [3:0]       live_idx;
  key_info_t        cand_info;

  assign any_low   = ~&row_sync;
  assign live_idx  = {col_idx, first_low_row(row_sync)};
  assign cand_info = decode_key(cand);

  // Two-flop synchronizer for the asynchronous row inputs
  always_ff @(posedge clk) begin
    if (reset) begin
      row_meta <= '0;
      row_sync <= '0;
    end else begin
      row_meta <= row;
      row_sync <= row_meta;
    end
  end

  key_debounce_counter #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_deb (
    .clk    (clk),
    .reset  (reset),
    .clear  (deb_clear),
    .enable (deb_enable),
    .done   (deb_done)
  );

  // State, column, candidate and registered press outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= SCAN;
      col_idx    <= 2'd0;
      col        <= 4'b1110;
      div_cnt    <= '0;
      cand       <= 4'd0;
      num        <= 4'd0;
      opt        <= 3'd0;
      numPressed <= 1'b0;
      optPressed <= 1'b0;
      submit     <= 1'b0;
    end else begin
      state      <= state_next;
      col_idx    <= col_idx_next;
      col        <= ~(4'b0001 << col_idx_next);
      div_cnt    <= div_next;
      cand       <= cand_next;
      num        <= num_next;
      opt        <= opt_next;
      numPressed <= num_pressed_next;
      optPressed <= opt_pressed_next;
      submit     <= submit_next;
    end
  end

  // Next-state, column advance, debounce control and press-output updates
  always_comb begin
    state_next       = state;
    col_idx_next     = col_idx;
    div_next         = div_cnt;
    cand_next        = cand;
    num_next         = num;
    opt_next         = opt;
    num_pressed_next = numPressed;
    opt_pressed_next = optPressed;
    submit_next      = submit;
    deb_clear        = 1'b0;
    deb_enable       = 1'b0;

    case (state)
      SCAN: begin
        deb_clear = 1'b1;
        if (div_cnt == DIV_LAST) begin
          div_next = '0;
          if (any_low) begin
            cand_next  = live_idx;
            state_next = PRESS_DEB;
          end else begin
            col_idx_next = col_idx + 2'd1;
          end
        end else begin
          div_next = div_cnt + 1'b1;
        end
      end

      PRESS_DEB: begin
        if (!any_low || (live_idx != cand)) begin
          state_next   = SCAN;
          col_idx_next = col_idx + 2'd1;
          div_next     = '0;
        end else if (deb_done) begin
          state_next = HELD;
          case (cand_info.cls)
            CLS_NUM: begin
              num_pressed_next = 1'b1;
              num_next         = cand_info.value;
            end
            CLS_OPT: begin
              opt_pressed_next = 1'b1;
              opt_next         = cand_info.value[2:0];
            end
            default: submit_next = 1'b1;
          endcase
        end else begin
          deb_enable = 1'b1;
        end
      end

      HELD: begin
        deb_clear = 1'b1;
        if (!any_low) state_next = REL_DEB;
      end

      REL_DEB: begin
        if (any_low) begin
          state_next = HELD;
          deb_clear  = 1'b1;
        end else if (deb_done) begin
          state_next       = SCAN;
          col_idx_next     = col_idx + 2'd1;
          div_next         = '0;
          num_next         = 4'd0;
          opt_next         = 3'd0;
          num_pressed_next = 1'b0;
          opt_pressed_next = 1'b0;
          submit_next      = 1'b0;
        end else begin
          deb_enable = 1'b1;
        end
      end

      default: state_next = SCAN;
    endcase
  end

endmodule : keypad_scanner
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : tb_keypad_scanner
//  Brief    : Self-checking bench for keypad_scanner with a keypad matrix
//             model and a key-table reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_keypad_scanner;

  localparam int SCAN_DIV   = 4;
  localparam int DEB_CYCLES = 8;
  localparam int RISE_MAX   = 4 * SCAN_DIV + DEB_CYCLES + 3;
  localparam int FALL_EXACT = DEB_CYCLES + 3;
  localparam int WAIT_LIMIT = 200;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  num;
  logic        numPressed;
  logic [2:0]  opt;
  logic        optPressed;
  logic        submit;
  logic [15:0] keys;

  int n_checks = 0;
  int n_errors = 0;
  int bad_col  = 0;

  keypad_scanner #(
    .SCAN_DIV   (SCAN_DIV),
    .DEB_CYCLES (DEB_CYCLES)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .row        (row),
    .col        (col),
    .num        (num),
    .numPressed (numPressed),
    .opt        (opt),
    .optPressed (optPressed),
    .submit     (submit)
  );

  always #5 clk = ~clk;

  // Keypad matrix: a pressed key pulls its row low while its column is driven
  always_comb begin
    row = 4'hF;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (!col[c] && keys[c*4 + r]) row[r] = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (!(col == 4'hE || col == 4'hD || col == 4'hB || col == 4'h7)) bad_col++;
  endtask

  function automatic logic any_pressed();
    return numPressed || optPressed || submit;
  endfunction

  task automatic wait_press(output int lat);
    lat = 0;
    while (!any_pressed() && lat < WAIT_LIMIT) begin
      tick();
      lat++;
    end
  endtask

  task automatic wait_release(output int lat);
    lat = 0;
    while (any_pressed() && lat < WAIT_LIMIT) begin
      tick();
      lat++;
    end
  endtask

  // Reference model: expected outputs for a held key, from the key table
  task automatic check_held(input string tag, input int idx);
    logic [3:0] e_num;
    logic [2:0] e_opt;
    logic       e_np, e_op, e_sub;
    e_np  = (idx < 10);
    e_op  = (idx >= 10) && (idx <= 14);
    e_sub = (idx == 15);
    e_num = e_np ? 4'(idx) : 4'd0;
    e_opt = !e_op ? 3'd0 : ((idx <= 12) ? 3'(idx - 10) : 3'(idx - 9));
    check({tag, "_numPressed"}, numPressed, e_np);
    check({tag, "_num"},        num,        e_num);
    check({tag, "_optPressed"}, optPressed, e_op);
    check({tag, "_opt"},        opt,        e_opt);
    check({tag, "_submit"},     submit,     e_sub);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_idle_outputs"}, {num, opt, numPressed, optPressed, submit}, 0);
  endtask

  // Full press / hold / release of a single key
  task automatic press_cycle(input int idx, input int hold);
    int   lat;
    int   changed;
    logic [10:0] snap;
    string tag;
    tag = $sformatf("key%0d", idx);
    keys = 16'd1 << idx;
    wait_press(lat);
    check({tag, "_rise_in_bound"}, (lat >= DEB_CYCLES) && (lat <= RISE_MAX), 1);
    check_held(tag, idx);
    snap = {num, opt, numPressed, optPressed, submit};
    changed = 0;
    repeat (hold) begin
      tick();
      if ({num, opt, numPressed, optPressed, submit} != snap) changed++;
    end
    check({tag, "_stable_while_held"}, changed, 0);
    keys = '0;
    wait_release(lat);
    check({tag, "_fall_latency"}, lat, FALL_EXACT);
    check_idle(tag);
  endtask

  initial begin
    int lat;
    int flag;
    keys  = '0;
    reset = 1'b1;
    repeat (3) tick();
    check("reset_col", col, 4'hE);
    check_idle("reset");
    reset = 1'b0;
    repeat (5) tick();

    // Digit key 7 at column 1 row 3, then the operator and submit corners
    press_cycle(7, 60);
    press_cycle(14, 10);
    press_cycle(15, 10);

    // Randomized keys and hold times
    for (int i = 0; i < 14; i++) begin
      press_cycle(int'($urandom_range(15, 0)), int'($urandom_range(20, 3)));
      repeat ($urandom_range(10, 0)) tick();
    end

    // Bouncing contact must never produce a press
    flag = 0;
    for (int i = 0; i < 40; i++) begin
      keys = (((i / 3) % 2) == 0) ? 16'h0008 : 16'h0000;
      tick();
      if (any_pressed()) flag++;
    end
    check("bounce_no_press", flag, 0);
    press_cycle(3, 10);

    // Two keys in one column: lower row wins; later keys ignored while held
    keys = 16'h0050;
    wait_press(lat);
    check("two_keys_rise_in_bound", lat <= RISE_MAX, 1);
    check_held("two_keys", 4);
    keys = keys | 16'h0200;
    flag = 0;
    repeat (30) begin
      tick();
      if (num != 4'd4 || !numPressed) flag++;
    end
    check("extra_key_ignored", flag, 0);
    keys = '0;
    wait_release(lat);
    check("two_keys_fall_latency", lat, FALL_EXACT);

    // Reset pulse mid-press, then full re-debounce
    keys = 16'h0004;
    wait_press(lat);
    check_held("pre_reset", 2);
    repeat (3) tick();
    reset = 1'b1;
    tick();
    check("reset_midpress_col", col, 4'hE);
    check_idle("reset_midpress");
    reset = 1'b0;
    wait_press(lat);
    check("reset_redetect_full_debounce", (lat >= DEB_CYCLES) && (lat <= RISE_MAX), 1);
    check_held("post_reset", 2);
    keys = '0;
    wait_release(lat);
    check("post_reset_fall_latency", lat, FALL_EXACT);

    // Short release glitch must not drop the press
    keys = 16'h0020;
    wait_press(lat);
    flag = 0;
    repeat (10) begin tick(); if (!numPressed) flag++; end
    keys = '0;
    repeat (5) begin tick(); if (!numPressed) flag++; end
    keys = 16'h0020;
    repeat (30) begin tick(); if (!numPressed) flag++; end
    check("glitch_no_fall", flag, 0);
    check_held("glitch", 5);
    keys = '0;
    wait_release(lat);
    check("glitch_fall_latency", lat, FALL_EXACT);

    check("col_always_onehot_low", bad_col, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_keypad_scanner
`default_nettype wire
